// File: rtl/move_link_rx_if.sv
// ============================================================================
//  Module   : move_link_rx_if
//  Purpose  : RX FIFO read handshake between the UART receive FIFO and the
//             chess-link frame decoder.
//  Signals  : rx_empty - FIFO empty flag (FIFO -> decoder)
//             r_data   - FIFO head word, valid while rx_empty=0
//             rd_uart  - one-cycle pop strobe (decoder -> FIFO)
//  Modports : master - FIFO side, slave - decoder side
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface move_link_rx_if;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;

    modport master (output rx_empty, output r_data, input rd_uart);
    modport slave  (input rx_empty, input r_data, output rd_uart);
endinterface

`default_nettype wire

// File: rtl/move_link_rx.sv
// ============================================================================
//  Module   : move_link_rx
//  Purpose  : Receive-side protocol decoder for the two-board chess link.
//             Pops 8-bit frames from the RX FIFO and turns them into opponent
//             pick/place events, completed moves and turn hand-over.
//             Frame: bit7 = next_turn, bits6:1 = square, bit0 = pick(1)/place(0)
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             fifo (slave)      - rx_empty / r_data / rd_uart handshake
//             turn_done         - local player finished its move (pulse)
//             begin_turn        - local side has the turn (level)
//             oponent_pick      - opponent is holding a piece (level)
//             oponent_position  - square of the last accepted frame
//             move_valid        - completed opponent move (pulse)
//             move_from/move_to - squares of the last completed move
//             link_error        - protocol violation (pulse)
//             err_code          - 0 frame in local turn, 1 place w/o pick,
//                                 2 pick while holding, 3 pick timeout
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module move_link_rx #(
    parameter int PLAYER_FIRST   = 1,
    parameter int TIMEOUT_CYCLES = 750_000_000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    move_link_rx_if.slave   fifo,
    input  wire logic       turn_done,
    output logic            begin_turn,
    output logic            oponent_pick,
    output logic [5:0]      oponent_position,
    output logic            move_valid,
    output logic [5:0]      move_from,
    output logic [5:0]      move_to,
    output logic            link_error,
    output logic [1:0]      err_code
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        WAIT_PICK  = 1'b0,
        WAIT_PLACE = 1'b1
    } state_t;

    state_t           state;
    logic             rd_q;
    logic [5:0]       from_sq;
    logic [CNT_W-1:0] to_cnt;

    logic [5:0] frame_sq;
    logic       frame_pick;
    logic       frame_next_turn;

    assign frame_sq        = fifo.r_data[6:1];
    assign frame_pick      = fifo.r_data[0];
    assign frame_next_turn = fifo.r_data[7];
    assign fifo.rd_uart    = rd_q;

    // The pop strobe is registered; the frame is decoded on the cycle the
    // strobe is high (the FIFO head is stable until the pop edge), so the
    // decoded outputs appear one cycle after rd_uart.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q             <= 1'b0;
            begin_turn       <= (PLAYER_FIRST != 0);
            oponent_pick     <= 1'b0;
            oponent_position <= 6'd0;
            move_valid       <= 1'b0;
            move_from        <= 6'd0;
            move_to          <= 6'd0;
            link_error       <= 1'b0;
            err_code         <= 2'd0;
            state            <= WAIT_PICK;
            from_sq          <= 6'd0;
            to_cnt           <= '0;
        end else begin
            // Never pop on two consecutive cycles: the FIFO needs a cycle
            // to present the next head word.
            rd_q       <= ~fifo.rx_empty & ~rd_q;
            move_valid <= 1'b0;
            link_error <= 1'b0;

            if (turn_done && begin_turn) begin
                begin_turn <= 1'b0;
            end

            if (rd_q) begin
                // begin_turn here is the pre-update value, so a frame that
                // coincides with turn_done is still judged as local-turn.
                if (begin_turn) begin
                    link_error <= 1'b1;
                    err_code   <= 2'd0;
                end else if (state == WAIT_PICK) begin
                    if (frame_pick) begin
                        oponent_pick     <= 1'b1;
                        oponent_position <= frame_sq;
                        from_sq          <= frame_sq;
                        to_cnt           <= '0;
                        state            <= WAIT_PLACE;
                    end else begin
                        link_error <= 1'b1;
                        err_code   <= 2'd1;
                    end
                end else begin
                    if (frame_pick) begin
                        // Second pick: latest square wins, timer restarts.
                        link_error       <= 1'b1;
                        err_code         <= 2'd2;
                        oponent_position <= frame_sq;
                        from_sq          <= frame_sq;
                        to_cnt           <= '0;
                    end else begin
                        oponent_pick     <= 1'b0;
                        oponent_position <= frame_sq;
                        state            <= WAIT_PICK;
                        // Placing back on the source square is not a move.
                        if (frame_sq != from_sq) begin
                            move_valid <= 1'b1;
                            move_from  <= from_sq;
                            move_to    <= frame_sq;
                            if (frame_next_turn) begin
                                begin_turn <= 1'b1;
                            end
                        end
                    end
                end
            end else if (state == WAIT_PLACE) begin
                // Expiry fires on the TIMEOUT_CYCLES-th edge after the pick.
                if (to_cnt == CNT_LAST) begin
                    oponent_pick <= 1'b0;
                    link_error   <= 1'b1;
                    err_code     <= 2'd3;
                    state        <= WAIT_PICK;
                    to_cnt       <= '0;
                end else begin
                    to_cnt <= to_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_move_link_rx.sv
// ============================================================================
//  Module   : tb_move_link_rx
//  Purpose  : Self-checking bench for move_link_rx. A queue stands in for
//             the RX FIFO; a cycle-level model of the link rules predicts
//             every output and is compared each cycle, plus literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_move_link_rx;

    localparam int PF = 0;
    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       turn_done = 1'b0;
    logic       begin_turn, oponent_pick, move_valid, link_error;
    logic [5:0] oponent_position, move_from, move_to;
    logic [1:0] err_code;

    move_link_rx_if ifc ();

    move_link_rx #(.PLAYER_FIRST(PF), .TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .fifo             (ifc.slave),
        .turn_done        (turn_done),
        .begin_turn       (begin_turn),
        .oponent_pick     (oponent_pick),
        .oponent_position (oponent_position),
        .move_valid       (move_valid),
        .move_from        (move_from),
        .move_to          (move_to),
        .link_error       (link_error),
        .err_code         (err_code)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int mv_count = 0;

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- FIFO stand-in ----------------
    logic [7:0] fifo_q[$];

    always @(negedge clk) begin
        ifc.rx_empty = (fifo_q.size() == 0);
        ifc.r_data   = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end

    // ---------------- behavioural model ----------------
    // The opponent either holds a piece (with a deadline in absolute edge
    // numbers) or not; each popped frame is applied by the link rules.
    int     m_rd, m_turn, m_hold, m_pos, m_mv, m_from, m_to, m_err, m_code;
    int     held_sq;
    longint edge_n = 0, deadline = 0;
    bit     model_live = 0;

    always @(posedge clk) begin
        logic [7:0] f;
        int sq, prev_rd, turn_before;
        edge_n++;
        f = ifc.r_data;
        if (rst) begin
            m_rd = 0; m_turn = PF; m_hold = 0; m_pos = 0; m_mv = 0;
            m_from = 0; m_to = 0; m_err = 0; m_code = 0; held_sq = 0;
        end else begin
            prev_rd     = m_rd;
            turn_before = m_turn;
            m_mv = 0; m_err = 0;
            if (turn_done && m_turn == 1) m_turn = 0;
            if (prev_rd == 1) begin
                sq = int'(f[6:1]);
                if (turn_before == 1) begin
                    m_err = 1; m_code = 0;
                end else if (f[0]) begin
                    if (m_hold == 1) begin m_err = 1; m_code = 2; end
                    m_hold = 1; held_sq = sq; m_pos = sq; deadline = edge_n + TO;
                end else if (m_hold == 0) begin
                    m_err = 1; m_code = 1;
                end else begin
                    m_hold = 0; m_pos = sq;
                    if (sq != held_sq) begin
                        m_mv = 1; m_from = held_sq; m_to = sq;
                        if (f[7]) m_turn = 1;
                    end
                end
            end else if (m_hold == 1 && edge_n == deadline) begin
                m_hold = 0; m_err = 1; m_code = 3;
            end
            m_rd = (!ifc.rx_empty && prev_rd == 0) ? 1 : 0;
        end
        if (ifc.rd_uart) void'(fifo_q.pop_front());
        model_live = 1;
    end

    // ---------------- per-cycle compare ----------------
    logic prev_rd_obs = 1'b0;

    always @(negedge clk) begin
        if (model_live) begin
            chk("rd_uart",          int'(ifc.rd_uart),    m_rd);
            chk("rd_uart_gap",      int'(ifc.rd_uart && prev_rd_obs), 0);
            chk("begin_turn",       int'(begin_turn),       m_turn);
            chk("oponent_pick",     int'(oponent_pick),     m_hold);
            chk("oponent_position", int'(oponent_position), m_pos);
            chk("move_valid",       int'(move_valid),       m_mv);
            chk("move_from",        int'(move_from),        m_from);
            chk("move_to",          int'(move_to),          m_to);
            chk("link_error",       int'(link_error),       m_err);
            chk("err_code",         int'(err_code),         m_code);
            if (move_valid) mv_count++;
            prev_rd_obs = ifc.rd_uart;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic int sig(input int which);
        case (which)
            0:       return int'(ifc.rd_uart);
            1:       return int'(move_valid);
            2:       return int'(link_error);
            default: return int'(oponent_pick);
        endcase
    endfunction

    task automatic wait_until(input string name, input int which, input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sig(which) == 0 && n < bound);
        chk(name, sig(which), 1);
    endtask

    task automatic pulse_turn_done();
        turn_done = 1'b1;
        @(negedge clk);
        turn_done = 1'b0;
    endtask

    initial begin
        int n, mv_before;
        ifc.rx_empty = 1'b1;
        ifc.r_data   = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_begin_turn", int'(begin_turn), 0);
        chk("rst_pick",       int'(oponent_pick), 0);
        chk("rst_err_code",   int'(err_code), 0);
        chk("rst_rd_uart",    int'(ifc.rd_uart), 0);
        rst = 1'b0;
        @(negedge clk);

        // pick square 12
        fifo_q.push_back(8'h19);
        wait_until("pick_pop", 0, 10);
        @(negedge clk);
        chk("pick_held", int'(oponent_pick), 1);
        chk("pick_pos",  int'(oponent_position), 12);
        chk("pick_noerr", int'(link_error), 0);

        // place square 28 with turn hand-over
        fifo_q.push_back(8'hB8);
        wait_until("move1_wait", 1, 10);
        chk("move1_from", int'(move_from), 12);
        chk("move1_to",   int'(move_to), 28);
        chk("move1_pick", int'(oponent_pick), 0);
        chk("move1_turn", int'(begin_turn), 1);

        // frame during local turn
        fifo_q.push_back(8'h19);
        wait_until("lturn_err_wait", 2, 10);
        chk("lturn_code", int'(err_code), 0);
        chk("lturn_pick", int'(oponent_pick), 0);
        pulse_turn_done();
        chk("turn_done_clears", int'(begin_turn), 0);

        // pick and put back on the same square
        mv_before = mv_count;
        fifo_q.push_back(8'h19);
        fifo_q.push_back(8'h18);
        repeat (10) @(negedge clk);
        chk("putback_nomove", mv_count - mv_before, 0);
        chk("putback_pick",   int'(oponent_pick), 0);
        chk("putback_pos",    int'(oponent_position), 12);
        chk("putback_turn",   int'(begin_turn), 0);

        // place without pick
        fifo_q.push_back(8'h38);
        wait_until("nopick_wait", 2, 10);
        chk("nopick_code", int'(err_code), 1);

        // double pick, then castling-style place without hand-over
        fifo_q.push_back(8'h19);
        fifo_q.push_back(8'h1B);
        wait_until("dpick_wait", 2, 20);
        chk("dpick_code", int'(err_code), 2);
        chk("dpick_pos",  int'(oponent_position), 13);
        chk("dpick_pick", int'(oponent_pick), 1);
        fifo_q.push_back(8'h3A);
        wait_until("castle_wait", 1, 10);
        chk("castle_from", int'(move_from), 13);
        chk("castle_to",   int'(move_to), 29);
        chk("castle_turn", int'(begin_turn), 0);

        // pick timeout
        fifo_q.push_back(8'h19);
        wait_until("to_pick_wait", 3, 10);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!link_error && n < 200);
        chk("to_cycles", n, TO);
        chk("to_code",   int'(err_code), 3);
        chk("to_pick",   int'(oponent_pick), 0);

        // back-to-back frames in the FIFO
        fifo_q.push_back(8'h19);
        fifo_q.push_back(8'hB8);
        wait_until("b2b_wait", 1, 20);
        chk("b2b_from", int'(move_from), 12);
        chk("b2b_to",   int'(move_to), 28);
        chk("b2b_turn", int'(begin_turn), 1);
        @(negedge clk);
        pulse_turn_done();

        // reset while holding a piece
        fifo_q.push_back(8'h19);
        wait_until("rstmid_pick_wait", 3, 10);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rstmid_pick", int'(oponent_pick), 0);
        fifo_q.push_back(8'hB8);
        wait_until("rstmid_err_wait", 2, 10);
        chk("rstmid_code", int'(err_code), 1);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
